// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the debug-port program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } loader_state_t;

  localparam int INSTR_BYTES = 4;
  localparam int DLY_W       = 16;

  function automatic logic state_is_busy(input loader_state_t s);
    return (s inside {ST_ACCEPT, ST_SETUP, ST_STROBE, ST_HOLD, ST_RELEASE});
  endfunction

endpackage

// File: rtl/loader_delay_cnt.sv
// Loadable down-counter with a zero flag; times the SETUP, HOLD and RELEASE phases.
module loader_delay_cnt
  import prog_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [DLY_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [DLY_W-1:0] cnt_q, cnt_d;

  // Loading N-1 on phase entry makes the phase last exactly N cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DLY_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/prog_loader_ctrl.sv
// Streams instruction words into cpuCore memory over the debug port, then releases core reset.
// Optional PROG_LOADER_CHECKSUM_EN adds a 32-bit running-sum check of the loaded program.
module prog_loader_ctrl
  import prog_loader_pkg::*;
#(
  parameter int              XLEN               = 64,
  parameter int              INSTRUCTION_LENGTH = 32,
  parameter logic [XLEN-1:0] BASE_ADDR          = '0,
  parameter int              MAX_WORDS          = 1024,
  parameter int              SETUP_CYCLES       = 2,
  parameter int              HOLD_CYCLES        = 1,
  parameter int              RESET_HOLD         = 4,
  localparam int             WC_W               = $clog2(MAX_WORDS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_start,
  input  logic                          load_abort,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INSTRUCTION_LENGTH-1:0] in_instr,
  input  logic                          in_last,
  output logic                          dbg_wr_en,
  output logic [XLEN-1:0]               dbg_addr,
  output logic [INSTRUCTION_LENGTH-1:0] dbg_instr,
  output logic                          core_rst,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [WC_W-1:0]               word_count
`ifdef PROG_LOADER_CHECKSUM_EN
  ,
  input  logic [31:0]                   chk_expected,
  output logic [31:0]                   chk_value
`endif
);

  loader_state_t                 state_q, state_d;
  logic [XLEN-1:0]               addr_q, addr_d;
  logic [INSTRUCTION_LENGTH-1:0] instr_q, instr_d;
  logic                          last_q, last_d;
  logic [WC_W-1:0]               wc_q, wc_d;
  logic                          err_q, err_d;
  logic                          dly_load;
  logic [DLY_W-1:0]              dly_val;
  logic                          dly_zero;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0]                   chk_q, chk_d;
`endif

  loader_delay_cnt u_dly (
    .clk        (clk),
    .rst        (rst),
    .load_i     (dly_load),
    .load_val_i (dly_val),
    .zero_o     (dly_zero)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    instr_d  = instr_q;
    last_d   = last_q;
    wc_d     = wc_q;
    err_d    = err_q;
    dly_load = 1'b0;
    dly_val  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
    chk_d    = chk_q;
`endif

    // A strobe cycle always completes, even when an abort arrives alongside it.
    if (state_q == ST_STROBE) begin
      wc_d = wc_q + WC_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_d = chk_q + 32'(instr_q);
`endif
    end

    if (state_is_busy(state_q) && load_abort) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_RUN: begin
          if (load_start && !load_abort) begin
            state_d = ST_ACCEPT;
            addr_d  = BASE_ADDR;
            wc_d    = '0;
            err_d   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_d   = '0;
`endif
          end
        end
        ST_ACCEPT: begin
          if (in_valid) begin
            if (wc_q == WC_W'(MAX_WORDS)) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              instr_d  = in_instr;
              last_d   = in_last;
              dly_load = 1'b1;
              dly_val  = DLY_W'(SETUP_CYCLES - 1);
              state_d  = ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          if (dly_zero) state_d = ST_STROBE;
        end
        ST_STROBE: begin
          dly_load = 1'b1;
          dly_val  = DLY_W'(HOLD_CYCLES - 1);
          state_d  = ST_HOLD;
        end
        ST_HOLD: begin
          if (dly_zero) begin
            if (last_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              if (chk_q != chk_expected) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
              end else
`endif
              begin
                dly_load = 1'b1;
                dly_val  = DLY_W'(RESET_HOLD - 1);
                state_d  = ST_RELEASE;
              end
            end else begin
              addr_d  = addr_q + XLEN'(INSTR_BYTES);
              state_d = ST_ACCEPT;
            end
          end
        end
        ST_RELEASE: begin
          if (dly_zero) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      instr_q <= '0;
      last_q  <= 1'b0;
      wc_q    <= '0;
      err_q   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      last_q  <= last_d;
      wc_q    <= wc_d;
      err_q   <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign in_ready   = (state_q == ST_ACCEPT);
  assign dbg_wr_en  = (state_q == ST_STROBE);
  assign busy       = state_is_busy(state_q);
  assign done       = (state_q == ST_RUN);
  assign core_rst   = (state_q != ST_RUN);
  assign dbg_addr   = addr_q;
  assign dbg_instr  = instr_q;
  assign err        = err_q;
  assign word_count = wc_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign chk_value  = chk_q;
`endif

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Self-checking bench for prog_loader_ctrl: directed scenarios plus randomized traffic against a timeline model.
module tb_prog_loader_ctrl;

  localparam int          XLEN = 64;
  localparam int          IL   = 32;
  localparam logic [63:0] BASE = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam int          MAXW = 5;
  localparam int          S    = 3;
  localparam int          H    = 2;
  localparam int          R    = 3;
  localparam int          WCW  = $clog2(MAXW + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            load_start, load_abort, in_valid, in_last;
  logic [IL-1:0]   in_instr;
  logic            in_ready, dbg_wr_en, core_rst, busy, done, err;
  logic [XLEN-1:0] dbg_addr;
  logic [IL-1:0]   dbg_instr;
  logic [WCW-1:0]  word_count;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0]     chk_expected, chk_value;
`endif

  prog_loader_ctrl #(
    .XLEN(XLEN), .INSTRUCTION_LENGTH(IL), .BASE_ADDR(BASE), .MAX_WORDS(MAXW),
    .SETUP_CYCLES(S), .HOLD_CYCLES(H), .RESET_HOLD(R)
  ) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_abort(load_abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_last(in_last),
    .dbg_wr_en(dbg_wr_en), .dbg_addr(dbg_addr), .dbg_instr(dbg_instr),
    .core_rst(core_rst), .busy(busy), .done(done), .err(err), .word_count(word_count)
`ifdef PROG_LOADER_CHECKSUM_EN
    , .chk_expected(chk_expected), .chk_value(chk_value)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [95:0] strobe_q[$];
  int chk_off = 0;

  // Model: a load is a sequence of word timelines; m_k counts cycles since the word handshake.
  typedef enum {M_IDLE, M_LOAD, M_REL, M_RUN} mmode_t;
  mmode_t      m_mode;
  int          m_k, m_rel, m_wc;
  logic [63:0] m_addr;
  logic [31:0] m_instr, m_sum;
  bit          m_last, m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_k = -1; m_rel = 0; m_wc = 0;
    m_addr = '0; m_instr = '0; m_sum = '0; m_last = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit strobe;
    if (rst) begin
      model_reset();
      return;
    end
    strobe = (m_mode == M_LOAD && m_k == S + 1);
    if (strobe) begin
      m_wc++;
      m_sum = m_sum + m_instr;
    end
    if ((m_mode == M_LOAD || m_mode == M_REL) && load_abort) begin
      m_err = 1; m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE, M_RUN:
          if (load_start && !load_abort) begin
            m_mode = M_LOAD; m_k = -1; m_addr = BASE; m_wc = 0; m_err = 0; m_sum = 0;
          end
        M_LOAD:
          if (m_k < 0) begin
            if (in_valid) begin
              if (m_wc == MAXW) begin
                m_err = 1; m_mode = M_IDLE;
              end else begin
                m_instr = in_instr; m_last = in_last; m_k = 1;
              end
            end
          end else if (m_k == S + H + 1) begin
            if (m_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              if (m_sum != chk_expected) begin
                m_err = 1; m_mode = M_IDLE;
              end else
`endif
              begin
                m_mode = M_REL; m_rel = R;
              end
            end else begin
              m_addr = m_addr + 64'd4; m_k = -1;
            end
          end else begin
            m_k++;
          end
        M_REL: begin
          m_rel--;
          if (m_rel == 0) m_mode = M_RUN;
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare();
    check("in_ready",   in_ready,   64'(m_mode == M_LOAD && m_k < 0));
    check("dbg_wr_en",  dbg_wr_en,  64'(m_mode == M_LOAD && m_k == S + 1));
    check("busy",       busy,       64'(m_mode == M_LOAD || m_mode == M_REL));
    check("done",       done,       64'(m_mode == M_RUN));
    check("core_rst",   core_rst,   64'(m_mode != M_RUN));
    check("err",        err,        64'(m_err));
    check("dbg_addr",   dbg_addr,   m_addr);
    check("dbg_instr",  dbg_instr,  64'(m_instr));
    check("word_count", word_count, 64'(m_wc));
`ifdef PROG_LOADER_CHECKSUM_EN
    check("chk_value",  chk_value,  64'(m_sum));
`endif
  endtask

  // One clock cycle: inputs are already driven; model advances at the edge, outputs compared at negedge.
  task automatic step();
`ifdef PROG_LOADER_CHECKSUM_EN
    chk_expected = m_sum + 32'(chk_off);
`endif
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    if (dbg_wr_en === 1'b1) strobe_q.push_back({dbg_addr, dbg_instr});
  endtask

  task automatic pulse_start();
    load_start = 1; step(); load_start = 0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin step(); n++; end
    if (n >= 100) check("ready_timeout", 64'(n), 64'd0);
  endtask

  task automatic send_word(input logic [31:0] w, input bit last);
    int n;
    in_valid = 1; in_instr = w; in_last = last;
    wait_ready(n);
    step();
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_settle();
    int n = 0;
    while (busy === 1'b1 && n < 100) begin step(); n++; end
    if (n >= 100) check("settle_timeout", 64'(n), 64'd0);
  endtask

  initial begin
    int lat;
    rst = 1; load_start = 0; load_abort = 0; in_valid = 0; in_last = 0; in_instr = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
    chk_expected = '0;
`endif
    model_reset();
    @(negedge clk);
    compare();
    check("rst_core_rst", core_rst, 64'd1);
    check("rst_addr", dbg_addr, 64'd0);
    check("rst_wc", word_count, 64'd0);
    step(); step();
    rst = 0;
    step();

    // Three-word load with a 5-cycle stall before word 2; address wraps past 2^64.
    strobe_q.delete();
    pulse_start();
    send_word(32'h0010_8013, 0);
    wait_ready(lat);
    check("latency", 64'(lat), 64'(S + H + 1));
    repeat (5) step();
    check("stall_addr", dbg_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("stall_strobes", 64'(strobe_q.size()), 64'd1);
    send_word(32'h0011_2093, 0);
    send_word(32'h0011_3113, 1);
    wait_settle();
    check("t1_strobes", 64'(strobe_q.size()), 64'd3);
    check("t1_a0", strobe_q[0][95:32], 64'hFFFF_FFFF_FFFF_FFF8);
    check("t1_a2", strobe_q[2][95:32], 64'h0);
    check("t1_d2", 64'(strobe_q[2][31:0]), 64'h0011_3113);
    check("t1_done", done, 64'd1);
    check("t1_wc", word_count, 64'd3);

    // Reload from RUN with a single word.
    strobe_q.delete();
    pulse_start();
    check("reload_core_rst", core_rst, 64'd1);
    send_word(32'hCAFE_0001, 1);
    wait_settle();
    check("reload_strobes", 64'(strobe_q.size()), 64'd1);
    check("reload_addr", strobe_q[0][95:32], BASE);
    check("reload_core_run", core_rst, 64'd0);

    // Overflow: MAXW+1 words without a last flag.
    strobe_q.delete();
    pulse_start();
    for (int i = 0; i <= MAXW; i++) send_word(32'(i + 16), 0);
    step();
    check("ovf_strobes", 64'(strobe_q.size()), 64'(MAXW));
    check("ovf_err", err, 64'd1);
    check("ovf_core_rst", core_rst, 64'd1);
    check("ovf_wc", word_count, 64'(MAXW));

    // Abort during SETUP of word 2, then restart.
    strobe_q.delete();
    pulse_start();
    check("start_clears_err", err, 64'd0);
    send_word(32'h1111_1111, 0);
    send_word(32'h2222_2222, 0);
    load_abort = 1; step(); load_abort = 0;
    step();
    check("abort_err", err, 64'd1);
    check("abort_busy", busy, 64'd0);
    check("abort_strobes", 64'(strobe_q.size()), 64'd1);
    pulse_start();
    check("restart_err", err, 64'd0);
    check("restart_addr", dbg_addr, BASE);
    send_word(32'h3333_3333, 1);
    wait_settle();

`ifdef PROG_LOADER_CHECKSUM_EN
    pulse_start();
    for (int i = 1; i <= 3; i++) send_word(32'(i), i == 3);
    wait_settle();
    check("chk_sum", chk_value, 64'd6);
    check("chk_ok_done", done, 64'd1);
    chk_off = 1;
    pulse_start();
    for (int i = 1; i <= 3; i++) send_word(32'(i), i == 3);
    wait_settle();
    check("chk_bad_err", err, 64'd1);
    check("chk_bad_core_rst", core_rst, 64'd1);
    chk_off = 0;
`endif

    // Randomized traffic, including occasional async reset.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst = 1; step(); rst = 0;
      end
      load_start = ($urandom_range(0, 29) == 0);
      load_abort = !load_start && ($urandom_range(0, 149) == 0);
      in_valid   = ($urandom_range(0, 9) < 6);
      in_last    = ($urandom_range(0, 3) == 0);
      in_instr   = $urandom;
      chk_off    = ($urandom_range(0, 3) == 0) ? 1 : 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
